// File: rtl/svk_crg_rst_seq.sv
// Reset release sequencer: holds RST_NUM reset domains low until the PLL has been
// locked for HOLD_CYC cycles, then releases them in index order with per-stage delays.
module svk_crg_rst_seq #(
  parameter int RST_NUM  = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pll_lock,
  input  logic                     sw_rst_req,
  input  logic [RST_NUM*CNT_W-1:0] cfg_dly,
  output logic [RST_NUM-1:0]       rst_out_n,
  output logic                     busy,
  output logic                     done
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int STG_W  = (RST_NUM > 1) ? $clog2(RST_NUM) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_DLY  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [CNT_W-1:0]       r_dly_cnt;
  logic [STG_W-1:0]       r_stage;
  logic [RST_NUM*CNT_W-1:0] r_dly_sh;
  logic [RST_NUM-1:0]     r_rst_out_n;

  logic                   w_restart;
  logic                   w_hold_last;
  logic                   w_stage_last;
  logic [CNT_W-1:0]       w_cur_dly;

  // Losing lock only restarts once the sequence has left HOLD; in HOLD it just resets the lock timer.
  assign w_restart    = sw_rst_req | (~pll_lock & (r_state != ST_HOLD));
  assign w_hold_last  = (r_hold_cnt == HOLD_W'(HOLD_CYC - 1));
  assign w_stage_last = (r_stage == STG_W'(RST_NUM - 1));

  always_comb begin
    w_cur_dly = '0;
    for (int i = 0; i < RST_NUM; i++) begin
      if (r_stage == STG_W'(i)) w_cur_dly = r_dly_sh[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_stage     <= '0;
      r_dly_sh    <= '0;
      r_rst_out_n <= '0;
    end else if (w_restart) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_dly_cnt   <= '0;
      r_stage     <= '0;
      r_rst_out_n <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_rst_out_n <= '0;
          if (!pll_lock) begin
            r_hold_cnt <= '0;
          end else if (w_hold_last) begin
            r_state    <= ST_DLY;
            r_hold_cnt <= '0;
            r_stage    <= '0;
            r_dly_cnt  <= '0;
            r_dly_sh   <= cfg_dly;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_DLY: begin
          // Stage i spans dly_sh[i]+1 edges: count 0..dly_sh[i], release on the match.
          if (r_dly_cnt == w_cur_dly) begin
            for (int i = 0; i < RST_NUM; i++) begin
              if (r_stage == STG_W'(i)) r_rst_out_n[i] <= 1'b1;
            end
            r_dly_cnt <= '0;
            if (w_stage_last) r_state <= ST_DONE;
            else              r_stage <= r_stage + 1'b1;
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        ST_DONE: begin
        end
        default: begin
          r_state     <= ST_HOLD;
          r_rst_out_n <= '0;
        end
      endcase
    end
  end

  assign rst_out_n = r_rst_out_n;
  assign busy      = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_svk_crg_rst_seq.sv
// Bench for svk_crg_rst_seq: per-cycle comparison against an abstract release-time
// model, directed edge-exact checks, then randomized lock/restart/config traffic.
module tb_svk_crg_rst_seq;

  localparam int RST_NUM  = 4;
  localparam int CNT_W    = 8;
  localparam int HOLD_CYC = 4;
  localparam logic [31:0] BASIC = {8'd3, 8'd2, 8'd0, 8'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n      = 1'b0;
  logic                     pll_lock   = 1'b0;
  logic                     sw_rst_req = 1'b0;
  logic [RST_NUM*CNT_W-1:0] cfg_dly    = '0;
  logic [RST_NUM-1:0]       rst_out_n;
  logic                     busy;
  logic                     done;

  svk_crg_rst_seq #(.RST_NUM(RST_NUM), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .cfg_dly    (cfg_dly),
    .rst_out_n  (rst_out_n),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Abstract model: phase 0 = waiting for lock, 1 = releasing, 2 = all released.
  int ecnt    = 0;
  int m_phase = 0;
  int m_hold  = 0;
  int m_t     = 0;
  int m_rel   = 0;
  int m_dly[RST_NUM];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @E%0d t=%0t: got %0h, expected %0h", nm, ecnt, $time, act, exp);
    end
  endtask

  // Domains released after t edges of the release phase: domain i is free once
  // the running sum of (delay+1) up to and including i has elapsed.
  function automatic int released_after(input int t);
    int cum = 0;
    int rel = 0;
    for (int i = 0; i < RST_NUM; i++) begin
      cum += m_dly[i] + 1;
      if (cum <= t) rel = i + 1;
    end
    return rel;
  endfunction

  function automatic logic [31:0] exp_vec();
    return (32'd1 << m_rel) - 32'd1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      ecnt = 0; m_phase = 0; m_hold = 0; m_t = 0; m_rel = 0;
    end else begin
      ecnt++;
      if (sw_rst_req || (!pll_lock && m_phase != 0)) begin
        m_phase = 0; m_hold = 0; m_rel = 0;
      end else if (m_phase == 0) begin
        if (!pll_lock) m_hold = 0;
        else begin
          m_hold++;
          if (m_hold == HOLD_CYC) begin
            m_phase = 1; m_t = 0; m_hold = 0;
            for (int i = 0; i < RST_NUM; i++) m_dly[i] = int'(cfg_dly[i*CNT_W +: CNT_W]);
          end
        end
      end else if (m_phase == 1) begin
        m_t++;
        m_rel = released_after(m_t);
        if (m_rel == RST_NUM) m_phase = 2;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("cyc_rst_out_n", 32'(rst_out_n), exp_vec());
    chk("cyc_busy", 32'(busy), 32'(m_phase != 2));
    chk("cyc_done", 32'(done), 32'(m_phase == 2));
  end

  task automatic at_edge(input int n);
    int g = 0;
    do begin
      @(posedge clk);
      #3;
      g++;
    end while (ecnt < n && g < 5000);
    if (ecnt != n) begin
      n_fail++;
      n_cmp++;
      $display("FAIL edge_wait: reached E%0d, expected E%0d", ecnt, n);
    end
  endtask

  task automatic start_run(input logic [31:0] cfg, input logic lock);
    @(negedge clk);
    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    pll_lock   = lock;
    cfg_dly    = cfg;
    repeat (2) @(negedge clk);
    chk("rst_state_out", 32'(rst_out_n), 32'h0);
    chk("rst_state_busy", 32'(busy), 32'h1);
    chk("rst_state_done", 32'(done), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string nm, input logic [3:0] e_out, input logic e_busy, input logic e_done);
    chk({nm, "_out"}, 32'(rst_out_n), 32'(e_out));
    chk({nm, "_busy"}, 32'(busy), 32'(e_busy));
    chk({nm, "_done"}, 32'(done), 32'(e_done));
  endtask

  function automatic logic [31:0] rand_cfg();
    logic [31:0] c;
    for (int i = 0; i < RST_NUM; i++)
      c[i*8 +: 8] = ($urandom_range(0, 24) == 0) ? 8'hFF : 8'($urandom_range(0, 5));
    return c;
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic release
    start_run(BASIC, 1'b1);
    at_edge(4);  lit("basic_e4", 4'b0000, 1, 0);
    at_edge(5);  lit("basic_e5", 4'b0000, 1, 0);
    at_edge(6);  lit("basic_e6", 4'b0001, 1, 0);
    at_edge(7);  lit("basic_e7", 4'b0011, 1, 0);
    at_edge(9);  lit("basic_e9", 4'b0011, 1, 0);
    at_edge(10); lit("basic_e10", 4'b0111, 1, 0);
    at_edge(13); lit("basic_e13", 4'b0111, 1, 0);
    at_edge(14); lit("basic_e14", 4'b1111, 0, 1);

    // Zero delays
    start_run(32'h0, 1'b1);
    at_edge(4); lit("zero_e4", 4'b0000, 1, 0);
    at_edge(5); lit("zero_e5", 4'b0001, 1, 0);
    at_edge(6); lit("zero_e6", 4'b0011, 1, 0);
    at_edge(7); lit("zero_e7", 4'b0111, 1, 0);
    at_edge(8); lit("zero_e8", 4'b1111, 0, 1);

    // Late lock: high from E11
    start_run(BASIC, 1'b0);
    at_edge(10); lit("late_e10", 4'b0000, 1, 0);
    pll_lock = 1'b1;
    at_edge(15); lit("late_e15", 4'b0000, 1, 0);
    at_edge(16); lit("late_e16", 4'b0001, 1, 0);

    // Software restart sampled at E8
    start_run(BASIC, 1'b1);
    at_edge(7);  lit("sw_e7", 4'b0011, 1, 0);
    sw_rst_req = 1'b1;
    at_edge(8);  sw_rst_req = 1'b0; lit("sw_e8", 4'b0000, 1, 0);
    at_edge(13); lit("sw_e13", 4'b0000, 1, 0);
    at_edge(14); lit("sw_e14", 4'b0001, 1, 0);
    at_edge(21); lit("sw_e21", 4'b0111, 1, 0);
    at_edge(22); lit("sw_e22", 4'b1111, 0, 1);

    // Lock loss in DONE at E20
    start_run(BASIC, 1'b1);
    at_edge(19); lit("lock_e19", 4'b1111, 0, 1);
    pll_lock = 1'b0;
    at_edge(20); lit("lock_e20", 4'b0000, 1, 0);
    pll_lock = 1'b1;

    // Restart colliding with the final release at E14
    start_run(BASIC, 1'b1);
    at_edge(13); lit("coll_e13", 4'b0111, 1, 0);
    sw_rst_req = 1'b1;
    at_edge(14); sw_rst_req = 1'b0; lit("coll_e14", 4'b0000, 1, 0);
    at_edge(19); lit("coll_e19", 4'b0000, 1, 0);

    // Config changed after the latch edge
    start_run(BASIC, 1'b1);
    at_edge(4);  cfg_dly = '1;
    at_edge(6);  lit("iso_e6", 4'b0001, 1, 0);
    at_edge(7);  lit("iso_e7", 4'b0011, 1, 0);
    at_edge(9);  lit("iso_e9", 4'b0011, 1, 0);
    at_edge(10); lit("iso_e10", 4'b0111, 1, 0);
    at_edge(14); lit("iso_e14", 4'b1111, 0, 1);

    // Asynchronous reset mid-release, checked before the next clock edge
    start_run(BASIC, 1'b1);
    at_edge(8); lit("async_e8", 4'b0011, 1, 0);
    #1 rst_n = 1'b0;
    #2 lit("async_now", 4'b0000, 1, 0);

    // Randomized lock drops, restart pulses and config churn
    for (int r = 0; r < 12; r++) begin
      start_run(rand_cfg(), 1'b1);
      repeat (250) begin
        @(negedge clk);
        sw_rst_req = ($urandom_range(0, 59) == 0);
        if (pll_lock) pll_lock = !($urandom_range(0, 99) == 0);
        else          pll_lock = ($urandom_range(0, 3) == 0);
        cfg_dly = rand_cfg();
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/svk_crg_rst_seq.md
# svk_crg_rst_seq

Reset release sequencer for the clock/reset generator. It holds `RST_NUM` downstream reset domains asserted, waits for clock lock, and releases them one at a time in index order, with a programmable per-stage delay. Any of these events re-runs the whole sequence: a software reset request, loss of lock, or the primary reset. It sits between the primary reset pin and the per-domain reset nets.

## Interface
Parameters:
- `RST_NUM`, default 4: number of reset domains (≥1); domain 0 is released first.
- `CNT_W`, default 8: width of each per-stage delay field.
- `HOLD_CYC`, default 4: cycles all domains stay asserted with lock high before stage 0 starts (≥1).

Ports (clock and reset first):
- `clk`  in  1: sequencer clock (free-running reference).
- `rst_n`  in  1: reset; one clock, reset is asynchronous and active-low.
- `pll_lock`  in  1: clock-stable indication; level, already synchronous to `clk`.
- `sw_rst_req`  in  1: single-cycle request to re-run the full sequence.
- `cfg_dly`  in  `RST_NUM*CNT_W`: field i (bits `i*CNT_W +: CNT_W`) is the extra delay before releasing domain i.
- `rst_out_n`  out  `RST_NUM`: per-domain active-low resets; registered.
- `busy`  out  1: sequence in progress (state ≠ DONE).
- `done`  out  1: all domains released (state == DONE).

## Operation
- States are HOLD, DLY and DONE. Counters:
  - `hold_cnt`, width `$clog2(HOLD_CYC+1)`.
  - `dly_cnt`, width `CNT_W`.
  - `stage`, width `$clog2(RST_NUM)` (minimum 1).
- Shadow register `dly_sh[RST_NUM*CNT_W]`.
- Async reset (`rst_n`=0):
  - state=HOLD, `hold_cnt`=0, `dly_cnt`=0, `stage`=0.
  - `rst_out_n`=all 0, `busy`=1, `done`=0, `dly_sh`=0.
- HOLD:
  - All `rst_out_n` = 0.
  - If `pll_lock`=0, `hold_cnt` clears to 0.
  - Otherwise, if `hold_cnt`==HOLD_CYC-1: go to DLY, `stage`=0, `dly_cnt`=0, and latch `cfg_dly` into `dly_sh`.
  - Otherwise `hold_cnt` increments.
- DLY, at each edge:
  - If `dly_cnt`==`dly_sh[stage]`: set `rst_out_n[stage]`=1 and clear `dly_cnt`.
    - If `stage`==RST_NUM-1, go to DONE.
    - Otherwise `stage` increments.
  - Otherwise `dly_cnt` increments.
- DONE: hold all outputs; wait.
- Restart condition: `sw_rst_req`=1, or `pll_lock`=0 while in DLY or DONE. At the next edge, from any state:
  - `rst_out_n`=all 0, state=HOLD.
  - `hold_cnt`, `dly_cnt` and `stage` all cleared.
- Priority: restart > stage release > counting. A restart coinciding with the final release leaves all domains asserted and the state HOLD.
- `cfg_dly` is sampled only at the HOLD→DLY edge. Changes afterwards take effect only on the next sequence.
- Domains already released stay released during DLY; release order is strictly increasing index.
- Delay arithmetic: stage i lasts `dly_sh[i]`+1 cycles, with no wrap. A field value of 2^CNT_W-1 gives 2^CNT_W cycles.

## Timing
- Assertion of `rst_out_n` is asynchronous via `rst_n`; restart assertion is synchronous, one edge after the trigger.
- Release is always synchronous to `clk`.
- E1 is the first rising edge at which `rst_n`=1 is sampled, with `pll_lock`=1 held throughout.
  - HOLD→DLY occurs at edge E(HOLD_CYC).
  - `rst_out_n[i]` rises at edge E(HOLD_CYC + Σ_{j≤i}(`dly_sh[j]`+1)).
- `done` rises and `busy` falls at the same edge as `rst_out_n[RST_NUM-1]` rises.
- `busy` and `done` are decoded from registered state with no extra latency. On restart, `busy`=1 and `done`=0 from the edge that enters HOLD.
- If `pll_lock` is low at E1, counting begins at the first edge with lock high. HOLD then lasts HOLD_CYC lock-high edges.
- `rst_n` may deassert asynchronously. The bench drives it synchronised to `clk`.

## Test plan
- Basic release: RST_NUM=4, HOLD_CYC=4, `cfg_dly`={1,0,2,3} for domains 0..3, lock high, `rst_n` released → `rst_out_n[0..3]` rise at E6, E7, E10, E14; `done`=1 and `busy`=0 from E14.
- Zero delays: `cfg_dly`=0 for all fields → releases at E5, E6, E7, E8; `done` at E8.
- Late lock: `pll_lock`=0 for E1–E10, high from E11 → HOLD exits at E14; with the basic-release delays, domain 0 releases at E16.
- Software restart: basic-release config, `sw_rst_req` pulse sampled at E8 (domains 0 and 1 released) → all `rst_out_n`=0 after E8. Sequence re-runs counting from E9; domain 0 rises at E14, `done` at E22.
- Lock loss and final-edge collision, two cases:
  - `pll_lock` drops at E20 while in DONE → all domains assert at E20, `done`=0.
  - `sw_rst_req` sampled at E14 → `rst_out_n[3]` never rises and `done` stays 0.
- Config isolation and async reset:
  - Change `cfg_dly` to all 0xFF at E5 → release times are unchanged from the basic case.
  - Assert `rst_n` mid-DLY → all outputs go to 0 immediately without a clock edge, `busy`=1.
